// File: rtl/spi_ram_arb_if.sv
// Request/grant bundle for two requesters plus the SPI RAM command/data link.
// master = requesters and RAM side, slave = arbiter.
interface spi_ram_arb_if #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
);
  logic                   req0;
  logic                   req1;
  logic                   we0;
  logic                   we1;
  logic [ADDR_SIZE-1:0]   addr0;
  logic [ADDR_SIZE-1:0]   addr1;
  logic [MEM_WIDTH-1:0]   wdata0;
  logic [MEM_WIDTH-1:0]   wdata1;
  logic                   gnt0;
  logic                   gnt1;
  logic                   done0;
  logic                   done1;
  logic [MEM_WIDTH-1:0]   rdata0;
  logic [MEM_WIDTH-1:0]   rdata1;
  logic                   err;
  logic [MEM_WIDTH+1:0]   ram_din;
  logic                   ram_rx_valid;
  logic [MEM_WIDTH-1:0]   ram_dout;
  logic                   ram_tx_valid;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output ram_dout, ram_tx_valid,
    input  gnt0, gnt1, done0, done1,
    input  rdata0, rdata1, err,
    input  ram_din, ram_rx_valid
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  ram_dout, ram_tx_valid,
    output gnt0, gnt1, done0, done1,
    output rdata0, rdata1, err,
    output ram_din, ram_rx_valid
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Round-robin two-port arbiter in front of an SPI RAM command link.
// Define SPI_RAM_ARB_ADDR_CACHE_EN to skip repeated ADDR phases.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_WIDTH  = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_ram_arb_if.slave bus
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_RD} state_t;

  state_t               state;
  state_t               state_n;
  logic                 cur;
  logic                 last;
  logic                 we_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [MEM_WIDTH-1:0] wdata_q;
  logic [MEM_WIDTH-1:0] rdata0;
  logic [MEM_WIDTH-1:0] rdata1;
  logic [CW-1:0]        cnt;
  logic                 gnt0;
  logic                 gnt1;
  logic                 done0;
  logic                 done1;
  logic                 err;

  logic                 gnt0_n;
  logic                 gnt1_n;
  logic                 done0_n;
  logic                 done1_n;
  logic                 err_n;
  logic                 take;
  logic                 rd_hit;
  logic                 tmo;
  logic                 skip;
  logic                 rx;
  logic [MEM_WIDTH+1:0] din;

  logic                 pick;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [MEM_WIDTH-1:0] sel_wdata;

  // Contention goes to whoever was not served last.
  assign pick      = (bus.req0 & bus.req1) ? ~last : bus.req1;
  assign sel_we    = pick ? bus.we1    : bus.we0;
  assign sel_addr  = pick ? bus.addr1  : bus.addr0;
  assign sel_wdata = pick ? bus.wdata1 : bus.wdata0;

`ifdef SPI_RAM_ARB_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] c_addr;
  logic                 c_we;
  logic                 c_vld;

  assign skip = c_vld && (c_addr == sel_addr) && (c_we == sel_we);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_addr <= '0;
      c_we   <= 1'b0;
      c_vld  <= 1'b0;
    end else if (tmo) begin
      c_vld  <= 1'b0;
    end else if (state == ADDR) begin
      c_addr <= addr_q;
      c_we   <= we_q;
      c_vld  <= 1'b1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    done0_n = 1'b0;
    done1_n = 1'b0;
    err_n   = 1'b0;
    take    = 1'b0;
    rd_hit  = 1'b0;
    tmo     = 1'b0;
    rx      = 1'b0;
    din     = '0;
    unique case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          take    = 1'b1;
          gnt0_n  = ~pick;
          gnt1_n  = pick;
          state_n = skip ? DATA : ADDR;
        end
      end
      ADDR: begin
        rx      = 1'b1;
        din     = {we_q ? WR_ADDR : RD_ADDR, MEM_WIDTH'(addr_q)};
        state_n = DATA;
      end
      DATA: begin
        rx = 1'b1;
        if (we_q) begin
          din     = {WR_DATA, wdata_q};
          done0_n = ~cur;
          done1_n = cur;
          state_n = IDLE;
        end else begin
          din     = {RD_DATA, {MEM_WIDTH{1'b0}}};
          state_n = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (bus.ram_tx_valid) begin
          rd_hit  = 1'b1;
          done0_n = ~cur;
          done1_n = cur;
          state_n = IDLE;
        end else if (cnt == CW'(RD_TIMEOUT)) begin
          tmo     = 1'b1;
          err_n   = 1'b1;
          done0_n = ~cur;
          done1_n = cur;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur     <= 1'b0;
      last    <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state <= state_n;
      gnt0  <= gnt0_n;
      gnt1  <= gnt1_n;
      done0 <= done0_n;
      done1 <= done1_n;
      err   <= err_n;
      if (take) begin
        cur     <= pick;
        last    <= pick;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state == WAIT_RD && state_n == WAIT_RD)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      if (rd_hit | tmo) begin
        if (cur)
          rdata1 <= rd_hit ? bus.ram_dout : '0;
        else
          rdata0 <= rd_hit ? bus.ram_dout : '0;
      end
    end
  end

  assign bus.gnt0         = gnt0;
  assign bus.gnt1         = gnt1;
  assign bus.done0        = done0;
  assign bus.done1        = done1;
  assign bus.err          = err;
  assign bus.rdata0       = rdata0;
  assign bus.rdata1       = rdata1;
  assign bus.ram_din      = din;
  assign bus.ram_rx_valid = rx;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: stimulus pushes expected
// grants, RAM commands and completions; a negedge monitor pops them.
module tb_spi_ram_arbiter;
  localparam int T = 15;

  typedef struct {bit who; int cyc;} gnt_e;
  typedef struct {logic [9:0] din; int cyc;} cmd_e;
  typedef struct {bit who; bit chk; logic [7:0] rdata; bit err; int cyc;} done_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  gnt_e  gq[$];
  cmd_e  cq[$];
  done_e dq[$];

  bit         cv = 0;
  bit         ck = 0;
  logic [7:0] ca = '0;

  bit         respond = 0;
  bit         stray_req = 0;
  logic [7:0] rd_val = 8'hA5;

  spi_ram_arb_if #(.ADDR_SIZE(8), .MEM_WIDTH(8)) bus ();

  spi_ram_arbiter #(
    .ADDR_SIZE(8),
    .MEM_WIDTH(8),
    .RD_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok,
                       input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // RAM model: answers RD_DATA one cycle later when respond is set.
  initial begin
    bit pend;
    pend = 0;
    bus.ram_tx_valid = 1'b0;
    bus.ram_dout = 8'h00;
    forever begin
      @(negedge clk);
      bus.ram_tx_valid = pend | stray_req;
      bus.ram_dout = stray_req ? 8'hFF : rd_val;
      pend = respond && bus.ram_rx_valid && (bus.ram_din[9:8] == 2'b11);
    end
  end

  always @(negedge clk) begin
    gnt_e  ge;
    cmd_e  ce;
    done_e de;
    if (bus.gnt0 | bus.gnt1) begin
      if (gq.size() == 0) begin
        check("gnt_unexpected", 1'b0, {bus.gnt1, bus.gnt0}, 0);
      end else begin
        ge = gq.pop_front();
        check("gnt_who", (bus.gnt1 == ge.who) && (bus.gnt0 != ge.who),
              {bus.gnt1, bus.gnt0}, ge.who ? 2 : 1);
        if (ge.cyc >= 0)
          check("gnt_cycle", cyc == ge.cyc, cyc, ge.cyc);
      end
    end
    if (bus.ram_rx_valid) begin
      if (cq.size() == 0) begin
        check("cmd_unexpected", 1'b0, bus.ram_din, 0);
      end else begin
        ce = cq.pop_front();
        check("cmd_din", bus.ram_din == ce.din, bus.ram_din, ce.din);
        if (ce.cyc >= 0)
          check("cmd_cycle", cyc == ce.cyc, cyc, ce.cyc);
      end
    end else if (bus.ram_din != 10'h000) begin
      check("din_when_idle", 1'b0, bus.ram_din, 0);
    end
    if (bus.done0 | bus.done1) begin
      if (dq.size() == 0) begin
        check("done_unexpected", 1'b0, {bus.done1, bus.done0}, 0);
      end else begin
        de = dq.pop_front();
        check("done_who", (bus.done1 == de.who) && (bus.done0 != de.who),
              {bus.done1, bus.done0}, de.who ? 2 : 1);
        if (de.chk)
          check("done_rdata",
                (de.who ? bus.rdata1 : bus.rdata0) == de.rdata,
                de.who ? bus.rdata1 : bus.rdata0, de.rdata);
        check("done_err", bus.err == de.err, bus.err, de.err);
        if (de.cyc >= 0)
          check("done_cycle", cyc == de.cyc, cyc, de.cyc);
      end
    end else if (bus.err) begin
      check("err_without_done", 1'b0, bus.err, 0);
    end
  end

  function automatic int at(int base, int off);
    return (base < 0) ? -1 : base + off;
  endfunction

  // Expected model; gc = grant cycle, or -1 when timing is not pinned.
  task automatic push_txn(input bit who, input bit we, input logic [7:0] a,
                          input logic [7:0] wd, input bit resp,
                          input int gc, input bit with_done);
    bit skip;
    int dc;
    skip = 0;
`ifdef SPI_RAM_ARB_ADDR_CACHE_EN
    skip = cv && (ca == a) && (ck == we);
`endif
    gq.push_back('{who, gc});
    if (!skip)
      cq.push_back('{{(we ? 2'b00 : 2'b10), a}, gc});
    ca = a;
    ck = we;
    cv = 1;
    dc = at(gc, skip ? 0 : 1);
    cq.push_back('{we ? {2'b01, wd} : {2'b11, 8'h00}, dc});
    if (with_done) begin
      if (we)
        dq.push_back('{who, 1'b0, 8'h00, 1'b0, at(dc, 1)});
      else if (resp)
        dq.push_back('{who, 1'b1, rd_val, 1'b0, at(dc, 2)});
      else begin
        dq.push_back('{who, 1'b1, 8'h00, 1'b1, at(dc, T + 2)});
        cv = 0;
      end
    end
  endtask

  task automatic drive(input bit who, input bit we, input logic [7:0] a,
                       input logic [7:0] wd);
    if (who) begin
      bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.req1 = 1'b1;
    end else begin
      bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.req0 = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (gq.size() == 0 && cq.size() == 0 && dq.size() == 0) break;
    end
    if (i == 300) begin
      check("idle_timeout", 1'b0, gq.size() + cq.size() + dq.size(), 0);
      gq.delete(); cq.delete(); dq.delete();
    end
  endtask

  task automatic wait_gnt(input bit who);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (who ? bus.gnt1 : bus.gnt0) break;
    end
    if (i == 100) check("gnt_timeout", 1'b0, who, who);
  endtask

  task automatic issue(input bit who, input bit we, input logic [7:0] a,
                       input logic [7:0] wd, input bit resp);
    wait_idle();
    respond = resp;
    drive(who, we, a, wd);
    push_txn(who, we, a, wd, resp, cyc + 1, 1'b1);
    wait_gnt(who);
    if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    cv = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {bus.gnt1, bus.gnt0} == 2'b00, {bus.gnt1, bus.gnt0}, 0);
    check("rst_done", {bus.done1, bus.done0} == 2'b00, {bus.done1, bus.done0}, 0);
    check("rst_err", bus.err == 1'b0, bus.err, 0);
    check("rst_rdata0", bus.rdata0 == 8'h00, bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1 == 8'h00, bus.rdata1, 0);
    check("rst_rx_valid", bus.ram_rx_valid == 1'b0, bus.ram_rx_valid, 0);
    check("rst_din", bus.ram_din == 10'h000, bus.ram_din, 0);
    rst_n = 1'b1;

    issue(1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0);
    rd_val = 8'hA5;
    issue(1'b1, 1'b0, 8'h3C, 8'h00, 1'b1);

    // Stray read-data strobe while idle must not produce a done.
    wait_idle();
    stray_req = 1'b1;
    @(negedge clk); #1;
    stray_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    issue(1'b0, 1'b0, 8'h3C, 8'h00, 1'b0);
    wait_idle();

    // Contention from reset: expected order 0, 1, 0.
    do_reset();
    push_txn(1'b0, 1'b1, 8'h20, 8'h11, 1'b0, -1, 1'b1);
    push_txn(1'b1, 1'b1, 8'h21, 8'h22, 1'b0, -1, 1'b1);
    push_txn(1'b0, 1'b1, 8'h20, 8'h33, 1'b0, -1, 1'b1);
    #1;
    drive(1'b0, 1'b1, 8'h20, 8'h11);
    drive(1'b1, 1'b1, 8'h21, 8'h22);
    wait_gnt(1'b0);
    bus.wdata0 = 8'h33;
    wait_gnt(1'b1);
    bus.req1 = 1'b0;
    wait_gnt(1'b0);
    bus.req0 = 1'b0;
    wait_idle();

    // Reset while a write from requester 0 is in DATA.
    drive(1'b0, 1'b1, 8'h40, 8'h5A);
    push_txn(1'b0, 1'b1, 8'h40, 8'h5A, 1'b0, cyc + 1, 1'b0);
    wait_gnt(1'b0);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_rx_valid", bus.ram_rx_valid == 1'b0, bus.ram_rx_valid, 0);
    check("midrst_din", bus.ram_din == 10'h000, bus.ram_din, 0);
    check("midrst_done", {bus.done1, bus.done0} == 2'b00,
          {bus.done1, bus.done0}, 0);
    rst_n = 1'b1;
    cv = 0;
    push_txn(1'b0, 1'b1, 8'h50, 8'h66, 1'b0, -1, 1'b1);
    push_txn(1'b1, 1'b1, 8'h51, 8'h77, 1'b0, -1, 1'b1);
    drive(1'b0, 1'b1, 8'h50, 8'h66);
    drive(1'b1, 1'b1, 8'h51, 8'h77);
    wait_gnt(1'b0);
    bus.req0 = 1'b0;
    wait_gnt(1'b1);
    bus.req1 = 1'b0;

    issue(1'b0, 1'b1, 8'h10, 8'h01, 1'b0);
    issue(1'b0, 1'b1, 8'h10, 8'h02, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    #1;
    check("queues_drained", gq.size() + cq.size() + dq.size() == 0,
          gq.size() + cq.size() + dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8, RAM address width.
REQ-002 Parameter MEM_WIDTH, default 8, RAM data width; ram_din width is MEM_WIDTH+2.
REQ-003 Parameter RD_TIMEOUT, default 15, maximum cycles to wait for ram_tx_valid on a read.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req0, req1  input  1 each  requester transaction request, held high until matching gnt.
REQ-007 we0, we1  input  1 each  1 = write, 0 = read.
REQ-008 addr0, addr1  input  ADDR_SIZE each  target address.
REQ-009 wdata0, wdata1  input  MEM_WIDTH each  write data.
REQ-010 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted; fields latched.
REQ-011 done0, done1  output  1 each  one-cycle pulse: transaction complete.
REQ-012 rdata0, rdata1  output  MEM_WIDTH each  read result, valid from the done pulse until the next done to that requester.
REQ-013 err  output  1  one-cycle pulse with done on read timeout.
REQ-014 ram_din  output  MEM_WIDTH+2  command to RAM; [9:8] = control bits (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11), [7:0] = payload.
REQ-015 ram_rx_valid  output  1  ram_din qualifier.
REQ-016 ram_dout  input  MEM_WIDTH  RAM read data.
REQ-017 ram_tx_valid  input  1  RAM read-data qualifier.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, DATA, WAIT_RD.
REQ-019 In IDLE with any req high at edge N: the winner's gnt is 1 in cycle N+1; we/addr/wdata are latched; state becomes ADDR.
REQ-020 Arbitration SHALL be round-robin. With both requests high, grant the requester not granted last. A single request is always granted.
REQ-021 In ADDR: ram_rx_valid=1, ram_din={we?WR_ADDR:RD_ADDR, addr}; next state DATA.
REQ-022 In DATA: ram_rx_valid=1, ram_din={WR_DATA, wdata} for a write or {RD_DATA, 8'h00} for a read; next state IDLE for a write, WAIT_RD for a read.
REQ-023 Write: done pulses in the cycle after DATA (grant cycle+3). The arbiter can grant again at the following edge.
REQ-024 In WAIT_RD, ram_tx_valid=1 sampled at edge M: rdata<=ram_dout and done=1 in cycle M+1; state returns to IDLE.
REQ-025 A cycle counter SHALL count WAIT_RD cycles. After RD_TIMEOUT cycles without ram_tx_valid: rdata<=0, done=1, err=1, state IDLE.
REQ-026 ram_tx_valid outside WAIT_RD SHALL be ignored.
REQ-027 In IDLE and WAIT_RD: ram_rx_valid=0 and ram_din=0.
REQ-028 Requests arriving while not IDLE SHALL be held pending (no gnt) until IDLE.
REQ-029 gnt, done and err are single-cycle pulses. At most one gnt and one done are asserted per cycle.

Reset
REQ-030 rst_n=0 at an edge SHALL force state IDLE, gnt*=0, done*=0, err=0, rdata*=0, ram_rx_valid=0, ram_din=0, timeout counter=0, round-robin pointer favouring requester 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no done pulse. Outputs are at reset values in the cycle after the reset edge.

Configuration
REQ-032 Macro SPI_RAM_ARB_ADDR_CACHE_EN.
REQ-033 Defined: the arbiter tracks the last address sent, its kind (rd/wr) and a valid flag.
  - On grant, if valid and both address and kind match, IDLE goes directly to DATA and the ADDR phase is skipped.
  - Write done moves to grant cycle+2.
  - Reset and read timeout clear the valid flag.
REQ-034 Not defined: every transaction SHALL issue an ADDR phase; no cache registers are present.

Verification
REQ-035 Single write: req0, we0=1, addr0=8'h3C, wdata0=8'hA5.
  - gnt0 at N+1.
  - ram_din 10'h03C at N+1, then 10'h1A5 at N+2.
  - done0 at N+3.
REQ-036 Read: req1, we1=0, addr1=8'h3C; RAM returns tx_valid with dout=8'hA5 one cycle after RD_DATA.
  - ram_din 10'h23C then 10'h300.
  - rdata1=8'hA5 with done1.
REQ-037 Contention: req0 and req1 both held high across three transactions from reset.
  - Grant order is 0, 1, 0.
  - Never two gnt in one cycle.
REQ-038 Timeout: read with ram_tx_valid held 0.
  - done and err pulse exactly RD_TIMEOUT+1 cycles after WAIT_RD entry.
  - rdata=8'h00.
REQ-039 Reset in DATA state of a write.
  - Next cycle: ram_rx_valid=0, no done.
  - First grant after reset goes to requester 0.
REQ-040 With SPI_RAM_ARB_ADDR_CACHE_EN: two consecutive writes to 8'h10.
  - Second write shows no WR_ADDR command.
  - Its done arrives at grant+2.
